// File: rtl/msg_link_pkg.sv
// Shared definitions for the inter-machine message link (sender and receiver sides).
package msg_link_pkg;

    localparam int DEFAULT_MSG_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

endpackage

// File: rtl/msg_fifo.sv
// Small first-word-fall-through FIFO; head is readable combinationally so the
// sender can load a word in the same cycle it first sees the FIFO non-empty.
module msg_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    // Storage is not reset: only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/message_sender.sv
// Transmit end of the message link: queues host words, strobes each one to the
// remote receiver, retries on ack timeout and drops after the retry budget.
module message_sender
    import msg_link_pkg::*;
#(
    parameter int MSG_W     = DEFAULT_MSG_W,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 8,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [MSG_W-1:0] msg_in,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic             send,
    output logic [MSG_W-1:0] message,
    input  logic             ack,
    output logic             busy,
    output logic             drop_err,
    output logic [CNT_W-1:0] sent_count
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t           state_reg, state_next;
    logic [TW-1:0]    timer_reg, timer_next;
    logic [RW-1:0]    retry_reg, retry_next;
    logic [CNT_W-1:0] sent_count_reg, sent_count_next;
    logic [MSG_W-1:0] message_reg, message_next;
    logic             drop_err_reg, drop_err_next;

    logic             fifo_full;
    logic             fifo_empty;
    logic [MSG_W-1:0] fifo_head;
    logic             fifo_pop;

    msg_fifo #(
        .WIDTH (MSG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (msg_valid),
        .pop   (fifo_pop),
        .din   (msg_in),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_comb begin
        state_next      = state_reg;
        timer_next      = timer_reg;
        retry_next      = retry_reg;
        sent_count_next = sent_count_reg;
        message_next    = message_reg;
        drop_err_next   = 1'b0;
        fifo_pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    message_next = fifo_head;
                    state_next   = SEND;
                end
            end
            SEND: begin
                timer_next = '0;
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                // ack is checked first so a coincident ack beats the timeout.
                if (ack) begin
                    fifo_pop        = 1'b1;
                    sent_count_next = sent_count_reg + CNT_W'(1);
                    retry_next      = '0;
                    state_next      = IDLE;
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    if (retry_reg < RW'(MAX_RETRY)) begin
                        retry_next = retry_reg + RW'(1);
                        state_next = SEND;
                    end else begin
                        fifo_pop      = 1'b1;
                        drop_err_next = 1'b1;
                        retry_next    = '0;
                        state_next    = IDLE;
                    end
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            retry_reg      <= '0;
            sent_count_reg <= '0;
            message_reg    <= '0;
            drop_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            retry_reg      <= retry_next;
            sent_count_reg <= sent_count_next;
            message_reg    <= message_next;
            drop_err_reg   <= drop_err_next;
        end
    end

    assign msg_ready  = !fifo_full;
    assign send       = (state_reg == SEND);
    assign message    = message_reg;
    assign busy       = !fifo_empty || (state_reg != IDLE);
    assign drop_err   = drop_err_reg;
    assign sent_count = sent_count_reg;

endmodule

// File: tb/tb_message_sender.sv
// Directed bench for message_sender: single send, retry, drop, full FIFO,
// asynchronous reset mid-transfer, and ack/timeout collision.
module tb_message_sender;

    logic        clk;
    logic        reset;
    logic [31:0] msg_in;
    logic        msg_valid;
    logic        msg_ready;
    logic        send;
    logic [31:0] message;
    logic        ack;
    logic        busy;
    logic        drop_err;
    logic [15:0] sent_count;

    int n_cmp = 0;
    int n_err = 0;
    int send_total = 0;
    int drop_total = 0;

    message_sender #(
        .MSG_W     (32),
        .DEPTH     (4),
        .TIMEOUT   (8),
        .MAX_RETRY (2),
        .CNT_W     (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .msg_in     (msg_in),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .send       (send),
        .message    (message),
        .ack        (ack),
        .busy       (busy),
        .drop_err   (drop_err),
        .sent_count (sent_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (send)     send_total <= send_total + 1;
        if (drop_err) drop_total <= drop_total + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Wait (bounded) for a send strobe, check its word, then ack it in the first WAIT_ACK cycle.
    task automatic deliver(input logic [31:0] exp);
        for (int i = 0; i < 20 && !send; i++) tick();
        check("deliver_send", {31'd0, send}, 32'd1);
        check("deliver_msg", message, exp);
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        int s0;
        int d0;
        logic seen;

        reset     = 1'b1;
        msg_in    = '0;
        msg_valid = 1'b0;
        ack       = 1'b0;
        #3;
        check("rst_ready", {31'd0, msg_ready}, 32'd1);
        check("rst_send", {31'd0, send}, 32'd0);
        check("rst_message", message, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_drop", {31'd0, drop_err}, 32'd0);
        check("rst_count", {16'd0, sent_count}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        d0 = drop_total;

        // Single send, ack in the 2nd WAIT_ACK cycle
        msg_in = 32'd100; msg_valid = 1'b1;
        tick();
        msg_valid = 1'b0;
        check("t1_busy_after_push", {31'd0, busy}, 32'd1);
        check("t1_send_e0", {31'd0, send}, 32'd0);
        tick();
        check("t1_send_e1", {31'd0, send}, 32'd1);
        check("t1_message", message, 32'd100);
        tick();
        check("t1_send_e2", {31'd0, send}, 32'd0);
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t1_count", {16'd0, sent_count}, 32'd1);
        check("t1_busy_idle", {31'd0, busy}, 32'd0);

        // One retry, then ack right after the second send
        msg_in = 32'd7; msg_valid = 1'b1;
        tick();
        msg_valid = 1'b0;
        s0 = send_total;
        tick();
        check("t2_send1", {31'd0, send}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | send;
        end
        check("t2_no_send_between", {31'd0, seen}, 32'd0);
        tick();
        check("t2_send2", {31'd0, send}, 32'd1);
        check("t2_message", message, 32'd7);
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t2_count", {16'd0, sent_count}, 32'd2);
        check("t2_send_pulses", send_total - s0, 32'd2);
        check("t12_no_drop", drop_total - d0, 32'd0);

        // Drop after retries exhausted
        msg_in = 32'd55; msg_valid = 1'b1;
        tick();
        msg_valid = 1'b0;
        s0 = send_total;
        for (int i = 0; i < 27; i++) tick();
        check("t3_drop_early", {31'd0, drop_err}, 32'd0);
        check("t3_message", message, 32'd55);
        tick();
        check("t3_drop_pulse", {31'd0, drop_err}, 32'd1);
        check("t3_busy", {31'd0, busy}, 32'd0);
        check("t3_count", {16'd0, sent_count}, 32'd2);
        check("t3_send_pulses", send_total - s0, 32'd3);
        tick();
        check("t3_drop_one_cycle", {31'd0, drop_err}, 32'd0);
        check("t3_ready", {31'd0, msg_ready}, 32'd1);

        // Full FIFO: words 1..5 back-to-back, ack held off
        msg_valid = 1'b1; msg_in = 32'd1;
        tick();
        msg_in = 32'd2;
        tick();
        check("t4_msg1", message, 32'd1);
        msg_in = 32'd3;
        tick();
        msg_in = 32'd4;
        tick();
        check("t4_full_ready", {31'd0, msg_ready}, 32'd0);
        msg_in = 32'd5;
        tick();
        tick();
        check("t4_held_ready", {31'd0, msg_ready}, 32'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t4_ready_after_ack", {31'd0, msg_ready}, 32'd1);
        check("t4_count1", {16'd0, sent_count}, 32'd3);
        tick();
        msg_valid = 1'b0;
        check("t4_refull_ready", {31'd0, msg_ready}, 32'd0);
        deliver(32'd2);
        deliver(32'd3);
        deliver(32'd4);
        deliver(32'd5);
        check("t4_count5", {16'd0, sent_count}, 32'd7);
        tick();
        check("t4_busy_done", {31'd0, busy}, 32'd0);

        // Asynchronous reset during WAIT_ACK with two words queued
        msg_valid = 1'b1; msg_in = 32'd10;
        tick();
        msg_in = 32'd11;
        tick();
        msg_valid = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        check("t5_ready", {31'd0, msg_ready}, 32'd1);
        check("t5_send", {31'd0, send}, 32'd0);
        check("t5_message", message, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_drop", {31'd0, drop_err}, 32'd0);
        check("t5_count", {16'd0, sent_count}, 32'd0);
        tick();
        reset = 1'b0;
        s0 = send_total;
        for (int i = 0; i < 20; i++) tick();
        check("t5_no_send", send_total - s0, 32'd0);
        check("t5_busy_after", {31'd0, busy}, 32'd0);

        // Stray acks in IDLE and SEND, then ack on the timeout cycle
        d0 = drop_total;
        s0 = send_total;
        ack = 1'b1;
        tick();
        tick();
        ack = 1'b0;
        check("t6_idle_ack", {16'd0, sent_count}, 32'd0);
        msg_in = 32'd20; msg_valid = 1'b1;
        tick();
        msg_valid = 1'b0;
        tick();
        check("t6_send", {31'd0, send}, 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t6_send_ack_ignored", {16'd0, sent_count}, 32'd0);
        for (int i = 0; i < 7; i++) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t6_collision_count", {16'd0, sent_count}, 32'd1);
        check("t6_no_resend", {31'd0, send}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        tick();
        check("t6_no_drop", drop_total - d0, 32'd0);
        check("t6_send_pulses", send_total - s0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/message_sender.md
Name: message_sender

Overview:
- Transmit end of the inter-machine message link: buffers 32-bit messages from the local host and delivers them to a remote receiver as a send strobe plus message word.
- Waits for a receiver acknowledge; retries on timeout and drops the message after a bounded number of retries.
- One instance per direction (A to B, B to A), placed inside each machine wrapper alongside that machine's receiver.

Parameters:
- MSG_W, 32, message word width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- TIMEOUT, 8, cycles waited in WAIT_ACK per attempt; at least 1.
- MAX_RETRY, 2, resends after the first attempt before the message is dropped.
- CNT_W, 16, width of sent_count.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- msg_in  input  MSG_W  message word from the local host.
- msg_valid  input  1  host offers msg_in this cycle.
- msg_ready  output  1  FIFO can accept; a push occurs on msg_valid && msg_ready.
- send  output  1  one-cycle strobe to the remote receiver per attempt.
- message  output  MSG_W  word under transfer; stable from the SEND cycle through WAIT_ACK.
- ack  input  1  remote receiver acknowledge.
- busy  output  1  high while FIFO is non-empty or state is not IDLE.
- drop_err  output  1  one-cycle pulse when a message is discarded after retries are exhausted.
- sent_count  output  CNT_W  count of acknowledged messages.

Behaviour:
- Reset values:
  - Outputs: msg_ready=1, send=0, message=0, busy=0, drop_err=0, sent_count=0.
  - FIFO emptied; state IDLE; retry and timer counters 0.
- Reset asserted mid-transfer aborts it: the queued message is lost and no drop_err is raised.
- FIFO:
  - msg_ready = !full. When full, a push is refused even if a pop happens in the same cycle.
  - Pop happens only on completion (ack or drop). Push and pop in the same cycle are allowed when not full.
  - Pointers wrap modulo DEPTH.
- State machine, states IDLE, SEND, WAIT_ACK:
  - IDLE: if FIFO is non-empty, load the FIFO head into message and go to SEND. Otherwise stay.
  - SEND: send=1 for exactly this cycle. Clear timer, go to WAIT_ACK. ack is ignored in this cycle.
  - WAIT_ACK, send=0:
    - ack=1: pop FIFO, increment sent_count, clear retry counter, go to IDLE.
    - No ack and timer==TIMEOUT-1, retry<MAX_RETRY: increment retry, go to SEND with the same message.
    - No ack and timer==TIMEOUT-1, retry==MAX_RETRY: pop FIFO, pulse drop_err for 1 cycle, clear retry, go to IDLE.
    - Otherwise increment timer.
  - If ack and timeout coincide, ack wins.
- ack outside WAIT_ACK is ignored.
- Latency:
  - Push accepted at edge E0 into an empty, idle block: message is loaded at E1, send is high between E1 and E2.
  - Back-to-back messages: at least 3 cycles per message (IDLE, SEND, at least 1 WAIT_ACK cycle).
- message holds its last value in IDLE until the next load.
- sent_count wraps from 2^CNT_W-1 to 0 and has no saturation.
- Per message: attempts = 1+MAX_RETRY. Worst-case cycles before drop = (1+MAX_RETRY)*(1+TIMEOUT) + 1.

Decomposition:
- Package msg_link_pkg holds:
  - MSG_W default constant.
  - State enum type: IDLE, SEND, WAIT_ACK.
  - Shared by this block and the receiver-side ack logic.
- One sub-module, msg_fifo: parameterised by width and depth, with push/pop/full/empty/head.
- FSM, timer, retry counter and sent_count stay in message_sender.

Test Plan:
- Single send with ack:
  - Stimulus: push 32'd100 at E0; ack=1 in the 2nd WAIT_ACK cycle.
  - Required: send high E1–E2 only, message=100, sent_count=1, busy falls after return to IDLE, drop_err never pulses.
- One retry, then ack:
  - Stimulus: push 32'd7, no ack for TIMEOUT=8 cycles, then ack one cycle after the second send.
  - Required: exactly 2 send pulses 9 cycles apart, message=7 throughout, sent_count=1.
- Drop after retries exhausted:
  - Stimulus: push 32'd55, never ack.
  - Required: 3 send pulses, then a 1-cycle drop_err; FIFO empty, sent_count=0, state IDLE.
- Full FIFO:
  - Stimulus: hold ack=0 and push 5 words (1..5) back-to-back.
  - Required: first 4 accepted, msg_ready=0 while full, word 5 held off. After ack of word 1, msg_ready returns to 1 and word 5 is accepted. Delivery order 1,2,3,4,5.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously (between edges) during WAIT_ACK with 2 words queued.
  - Required: all outputs go to reset values immediately without a clock edge; after release with no pushes, no send pulse occurs.
- Ack/timeout collision and stray ack:
  - Stimulus: ack in the SEND cycle and in IDLE; then ack exactly on the timeout cycle.
  - Required: stray acks have no effect; the coincident ack is counted (sent_count+1, no retry, no drop_err).
